mod_stream_reduce: RTL and testbench



---
 rtl/mod_stream_reduce_pkg.sv | 26 ++
 rtl/mod_stream_reduce_if.sv | 38 +++
 rtl/mod_stream_reduce_fold_step.sv | 24 ++
 rtl/mod_stream_reduce.sv | 120 ++++++++++++
 tb/tb_mod_stream_reduce.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_stream_reduce_pkg.sv
// Package for the streaming modulo-M reducer: FSM state type and
// elaboration-time helpers for the folding constants and temp width.
package mod_stream_pkg;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 2^n mod m, evaluated by repeated doubling so it never overflows.
    function automatic int pow2_mod(input int n, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < n; i++) begin
            r = (r * 2) % m;
        end
        return r;
    endfunction

    // Width of the Horner temporary: holds acc*K + chunk without overflow.
    function automatic int t_width(input int mod_w, input int chunk_w);
        return (((2 * mod_w) > chunk_w) ? (2 * mod_w) : chunk_w) + 1;
    endfunction

endpackage

// File: rtl/mod_stream_reduce_if.sv
// Handshake bundle of the streaming reducer: chunk input stream and
// remainder output stream. slave = reducer side, master = source/sink side.
// Optional macro MODRED_ZERO_FLAG_EN adds the out_zero divisibility flag.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds valid and its data
// stable until that edge, and ready never depends on valid.
interface mod_stream_reduce_if #(
    parameter int CHUNK_W = 11,
    parameter int MOD_W   = 11
) ();
    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [MOD_W-1:0]   out_rem;
`ifdef MODRED_ZERO_FLAG_EN
    logic               out_zero;
`endif

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_rem
`ifdef MODRED_ZERO_FLAG_EN
        , output out_zero
`endif
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_rem
`ifdef MODRED_ZERO_FLAG_EN
        , input out_zero
`endif
    );
endinterface

// File: rtl/mod_stream_reduce_fold_step.sv
// One constant-multiply folding step: t -> lo + hi*C, where C = 2^MOD_W mod M.
// done flags that the upper part is already zero, i.e. t fits in MOD_W bits.
module mod_fold_step #(
    parameter int               MOD_W = 11,
    parameter int               T_W   = 23,
    parameter logic [MOD_W-1:0] C     = '0
) (
    input  logic [T_W-1:0]   t_in,
    output logic [T_W-1:0]   t_out,
    output logic [MOD_W-1:0] lo,
    output logic             done
);
    logic [T_W-MOD_W-1:0] hi;
    logic [T_W-1:0]       hi_ext;
    logic [T_W-1:0]       c_ext;

    assign hi     = t_in[T_W-1:MOD_W];
    assign lo     = t_in[MOD_W-1:0];
    assign hi_ext = T_W'(hi);
    assign c_ext  = T_W'(C);
    // Result is strictly below t_in whenever hi != 0, so T_W bits suffice.
    assign t_out  = T_W'(lo) + hi_ext * c_ext;
    assign done   = (hi == '0);
endmodule

// File: rtl/mod_stream_reduce.sv
// Streaming modulo-M reducer. Operand arrives MSB chunk first; each chunk is
// merged by Horner (acc*2^CHUNK_W + chunk), the temporary is folded down with
// the constant C until it fits MOD_W bits, then one conditional subtract.
// Optional macro MODRED_ZERO_FLAG_EN: adds out_zero (final remainder == 0).
module mod_stream_reduce
    import mod_stream_pkg::*;
#(
    parameter int MOD     = 2011,
    parameter int MOD_W   = 11,
    parameter int CHUNK_W = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_stream_reduce_if.slave   bus,
    output logic                 busy,
    output state_t               dbg_state
);
    localparam int K   = pow2_mod(CHUNK_W, MOD);
    localparam int C   = pow2_mod(MOD_W, MOD);
    localparam int T_W = t_width(MOD_W, CHUNK_W);

    localparam logic [MOD_W-1:0] M_V = MOD_W'(MOD);
    localparam logic [MOD_W-1:0] C_V = MOD_W'(C);
    localparam logic [T_W-1:0]   K_V = T_W'(K);

    state_t           state, state_d;
    logic [MOD_W-1:0] acc, acc_d;
    logic [T_W-1:0]   t, t_d;
    logic             last_q, last_d;
    logic             open_q, open_d;
    logic             zero_q, zero_d;

    logic [T_W-1:0]   fold_t;
    logic [MOD_W-1:0] fold_lo;
    logic             fold_done;

    mod_fold_step #(
        .MOD_W (MOD_W),
        .T_W   (T_W),
        .C     (C_V)
    ) u_fold (
        .t_in  (t),
        .t_out (fold_t),
        .lo    (fold_lo),
        .done  (fold_done)
    );

    // Next-state and datapath update for the ACC / FOLD / DONE sequence.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        t_d     = t;
        last_d  = last_q;
        open_d  = open_q;
        zero_d  = zero_q;
        case (state)
            ST_ACC: begin
                if (bus.in_valid) begin
                    t_d     = T_W'(acc) * K_V + T_W'(bus.in_data);
                    last_d  = bus.in_last;
                    open_d  = 1'b1;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                if (!fold_done) begin
                    t_d = fold_t;
                end else begin
                    // lo < 2^MOD_W < 2M, so a single subtract completes the reduction.
                    acc_d   = (fold_lo >= M_V) ? (fold_lo - M_V) : fold_lo;
                    zero_d  = last_q && (acc_d == '0);
                    state_d = last_q ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    open_d  = 1'b0;
                    zero_d  = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and datapath registers; reset aborts any open operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ACC;
            acc    <= '0;
            t      <= '0;
            last_q <= 1'b0;
            open_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            t      <= t_d;
            last_q <= last_d;
            open_q <= open_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = (state == ST_ACC);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_rem   = acc;
    assign busy          = !((state == ST_ACC) && (acc == '0) && !open_q);
    assign dbg_state     = state;

`ifdef MODRED_ZERO_FLAG_EN
    assign bus.out_zero  = zero_q;
`else
    logic unused_zero;
    assign unused_zero   = zero_q;
`endif
endmodule

// File: tb/tb_mod_stream_reduce.sv
// Bench for mod_stream_reduce (M=2011, 11-bit chunks): directed table,
// backpressure and mid-fold reset sequences, then random operands checked
// against a wide-integer X mod M reference.
module tb_mod_stream_reduce;
    import mod_stream_pkg::*;

    localparam int M  = 2011;
    localparam int CW = 11;
    localparam int MW = 11;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   busy;
    state_t dbg_state;

    mod_stream_reduce_if #(.CHUNK_W(CW), .MOD_W(MW)) tif ();

    mod_stream_reduce #(.MOD(M), .MOD_W(MW), .CHUNK_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (tif.slave),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] ops_q[$];
    logic [MW-1:0] exp_q[$];
    int            max_fold;
    bit            ready_in_fold;

    typedef struct {
        int            n;
        logic [CW-1:0] c[3];
        logic [MW-1:0] exp_rem;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait budget expired, got no event expected one", name);
    endtask

    // Reference: build the whole operand as one wide integer, then take X mod M.
    function automatic logic [MW-1:0] ref_mod();
        logic [511:0] x;
        x = '0;
        foreach (ops_q[i]) x = (x << CW) | 512'(ops_q[i]);
        x = x % 512'(M);
        return x[MW-1:0];
    endfunction

    task automatic send_chunk(input logic [CW-1:0] d, input logic l);
        int w;
        int fc;
        w = 0;
        @(negedge clk);
        tif.in_valid = 1'b1;
        tif.in_data  = d;
        tif.in_last  = l;
        while (!tif.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!tif.in_ready) timeout("accept");
        @(posedge clk);
        #1;
        tif.in_valid = 1'b0;
        fc = 0;
        while (dbg_state == ST_FOLD && fc < 20) begin
            if (tif.in_ready) ready_in_fold = 1'b1;
            fc++;
            @(posedge clk);
            #1;
        end
        if (fc > max_fold) max_fold = fc;
    endtask

    task automatic send_operand();
        max_fold = 0;
        ready_in_fold = 1'b0;
        foreach (ops_q[i]) send_chunk(ops_q[i], (i == ops_q.size() - 1));
    endtask

    task automatic get_result(input int hold, output logic [MW-1:0] rem, output logic z);
        int w;
        w = 0;
        while (!tif.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!tif.out_valid) timeout("out_valid");
        repeat (hold) @(negedge clk);
        @(negedge clk);
        rem = tif.out_rem;
`ifdef MODRED_ZERO_FLAG_EN
        z = tif.out_zero;
`else
        z = (tif.out_rem == '0);
`endif
        tif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tif.out_ready = 1'b0;
    endtask

    initial begin
        logic [MW-1:0] rem;
        logic          z;
        logic [MW-1:0] held;
        int            len;

        vecs[0] = '{1, '{11'd2047, 11'd0, 11'd0}, 11'd36};
        vecs[1] = '{2, '{11'd1, 11'd0, 11'd0}, 11'd37};
        vecs[2] = '{1, '{11'd2011, 11'd0, 11'd0}, 11'd0};
        vecs[3] = '{2, '{11'd2010, 11'd2010, 11'd0}, 11'd1973};
        vecs[4] = '{3, '{11'd0, 11'd0, 11'd5}, 11'd5};
        vecs[5] = '{3, '{11'd2047, 11'd2047, 11'd2047}, 11'd377};
        vecs[6] = '{1, '{11'd0, 11'd0, 11'd0}, 11'd0};

        tif.in_valid  = 1'b0;
        tif.in_data   = '0;
        tif.in_last   = 1'b0;
        tif.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(tif.in_ready), 1);
        check("rst_out_valid", 32'(tif.out_valid), 0);
        check("rst_out_rem", 32'(tif.out_rem), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef MODRED_ZERO_FLAG_EN
        check("rst_out_zero", 32'(tif.out_zero), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 7; v++) begin
            ops_q.delete();
            for (int i = 0; i < vecs[v].n; i++) ops_q.push_back(vecs[v].c[i]);
            send_operand();
            check($sformatf("vec%0d_busy", v), 32'(busy), 1);
            get_result(0, rem, z);
            check($sformatf("vec%0d_rem", v), 32'(rem), 32'(vecs[v].exp_rem));
`ifdef MODRED_ZERO_FLAG_EN
            check($sformatf("vec%0d_zero", v), 32'(z), 32'(vecs[v].exp_rem == '0));
`endif
            check($sformatf("vec%0d_fold_le4", v), 32'(max_fold <= 4 && max_fold >= 1), 1);
            check($sformatf("vec%0d_ready_in_fold", v), 32'(ready_in_fold), 0);
            check($sformatf("vec%0d_idle_busy", v), 32'(busy), 0);
        end

        // Backpressure in DONE
        ops_q.delete();
        ops_q.push_back(11'd100);
        ops_q.push_back(11'd7);
        send_operand();
        @(negedge clk);
        held = tif.out_rem;
        check("bp_rem", 32'(held), 32'(ref_mod()));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(tif.out_valid), 1);
            check("bp_stable", 32'(tif.out_rem), 32'(held));
            check("bp_in_ready", 32'(tif.in_ready), 0);
        end
        tif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tif.out_ready = 1'b0;
        check("bp_back_acc", 32'(dbg_state), 32'(ST_ACC));
        check("bp_out_valid_low", 32'(tif.out_valid), 0);
        ops_q.delete();
        ops_q.push_back(11'd5);
        send_operand();
        get_result(0, rem, z);
        check("bp_next_rem", 32'(rem), 5);

        // Asynchronous reset in the middle of a fold
        ops_q.delete();
        for (int i = 0; i < 36; i++) ops_q.push_back(11'($urandom_range(0, 2047)));
        ops_q[20] = 11'd2047;
        for (int i = 0; i < 20; i++) send_chunk(ops_q[i], 1'b0);
        @(negedge clk);
        tif.in_valid = 1'b1;
        tif.in_data  = ops_q[20];
        tif.in_last  = 1'b0;
        @(posedge clk);
        #1;
        tif.in_valid = 1'b0;
        check("mid_in_fold", 32'(dbg_state), 32'(ST_FOLD));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(tif.in_ready), 1);
        check("arst_out_valid", 32'(tif.out_valid), 0);
        check("arst_out_rem", 32'(tif.out_rem), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_state", 32'(dbg_state), 32'(ST_ACC));
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh 400-bit operand after the aborted one
        ops_q.delete();
        ops_q.push_back(11'($urandom_range(1, 15)));
        for (int i = 1; i < 37; i++) ops_q.push_back(11'($urandom_range(0, 2047)));
        exp_q.push_back(ref_mod());
        send_operand();
        get_result(0, rem, z);
        check("post_rst_400b", 32'(rem), 32'(exp_q.pop_front()));

        // Random operands
        for (int r = 0; r < 40; r++) begin
            ops_q.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0: ops_q.push_back(11'd2047);
                    1: ops_q.push_back(11'd2011);
                    2: ops_q.push_back(11'd0);
                    default: ops_q.push_back(11'($urandom_range(0, 2047)));
                endcase
            end
            exp_q.push_back(ref_mod());
            send_operand();
            get_result($urandom_range(0, 3), rem, z);
            held = exp_q.pop_front();
            check($sformatf("rand%0d_rem", r), 32'(rem), 32'(held));
`ifdef MODRED_ZERO_FLAG_EN
            check($sformatf("rand%0d_zero", r), 32'(z), 32'(held == '0));
`endif
            check($sformatf("rand%0d_fold", r), 32'(max_fold <= 4 && !ready_in_fold), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
